hls_core_staller_mc: RTL

//  Parametrised multi-channel stall controller for HLS-generated datapath cores
//  (fp converters, etc.). ANDs write-enable-complete flags from N_IN input and
//  N_OUT output channels into core_wen. Adds software halt with acknowledge,
//  per-channel stall-cause capture, saturating stall counters and a stall watchdog.

---
 rtl/hls_core_staller_mc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hls_core_staller_mc.sv
// Multi-channel stall controller for HLS datapath cores: combines channel
// write-enable-complete flags with a software halt and keeps stall statistics.
module hls_core_staller_mc #(
   parameter int N_IN     = 1,
   parameter int N_OUT    = 1,
   parameter int CNT_W    = 16,
   parameter int WDOG_CYC = 1024
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rst,
   input  logic [N_IN-1:0]        chn_in_wen_comp,
   input  logic [N_OUT-1:0]       chn_out_wen_comp,
   input  logic                   halt_req,
   input  logic                   stat_clr,
   output logic                   core_wen,
   output logic                   core_wten,
   output logic                   halt_ack,
   output logic [N_OUT+N_IN-1:0]  stall_cause,
   output logic [CNT_W-1:0]       stall_run,
   output logic [CNT_W-1:0]       stall_total,
   output logic                   wdog_hit
);

   localparam int                 CAUSE_W  = N_OUT + N_IN;
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   WDOG_VAL = CNT_W'(WDOG_CYC);

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   logic                 chn_ok_s;
   logic                 chn_stall_s;
   logic                 core_wen_s;
   logic                 wdog_trip_s;

   logic                 core_wten_q,   core_wten_d;
   logic                 halt_ack_q,    halt_ack_d;
   logic [CAUSE_W-1:0]   stall_cause_q, stall_cause_d;
   logic [CNT_W-1:0]     stall_run_q,   stall_run_d;
   logic [CNT_W-1:0]     stall_total_q, stall_total_d;
   logic                 wdog_hit_q,    wdog_hit_d;

   // Channel readiness and core enable, zero latency and independent of reset.
   always_comb begin
      chn_ok_s    = (&chn_in_wen_comp) & (&chn_out_wen_comp);
      chn_stall_s = ~chn_ok_s;
      core_wen_s  = chn_ok_s & ~halt_req;
   end

   // Next-state logic for all status registers.
   always_comb begin
      core_wten_d   = ~core_wen_s;
      halt_ack_d    = halt_req;
      stall_cause_d = {CAUSE_W{1'b0}};
      stall_run_d   = CNT_ZERO;
      stall_total_d = stall_total_q;
      wdog_trip_s   = 1'b0;
      wdog_hit_d    = wdog_hit_q;

      if (core_wen_s) begin
         stall_cause_d = {CAUSE_W{1'b0}};
      end else begin
         stall_cause_d = {~chn_out_wen_comp, ~chn_in_wen_comp};
      end

      // Halt-only cycles do not count as a channel stall run.
      if (chn_stall_s) begin
         stall_run_d = sat_inc(stall_run_q);
      end else begin
         stall_run_d = CNT_ZERO;
      end

      if (stat_clr) begin
         stall_total_d = CNT_ZERO;
      end else if (!core_wen_s) begin
         stall_total_d = sat_inc(stall_total_q);
      end else begin
         stall_total_d = stall_total_q;
      end

      // A saturated run no longer advances, so it cannot re-trip the watchdog.
      if (chn_stall_s && (stall_run_q != CNT_MAX) && (stall_run_d == WDOG_VAL)) begin
         wdog_trip_s = 1'b1;
      end else begin
         wdog_trip_s = 1'b0;
      end

      if (wdog_trip_s) begin
         wdog_hit_d = 1'b1;
      end else if (stat_clr) begin
         wdog_hit_d = 1'b0;
      end else begin
         wdog_hit_d = wdog_hit_q;
      end
   end

   // Status registers with synchronous reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         core_wten_q   <= 1'b0;
         halt_ack_q    <= 1'b0;
         stall_cause_q <= {CAUSE_W{1'b0}};
         stall_run_q   <= CNT_ZERO;
         stall_total_q <= CNT_ZERO;
         wdog_hit_q    <= 1'b0;
      end else begin
         core_wten_q   <= core_wten_d;
         halt_ack_q    <= halt_ack_d;
         stall_cause_q <= stall_cause_d;
         stall_run_q   <= stall_run_d;
         stall_total_q <= stall_total_d;
         wdog_hit_q    <= wdog_hit_d;
      end
   end

   assign core_wen    = core_wen_s;
   assign core_wten   = core_wten_q;
   assign halt_ack    = halt_ack_q;
   assign stall_cause = stall_cause_q;
   assign stall_run   = stall_run_q;
   assign stall_total = stall_total_q;
   assign wdog_hit    = wdog_hit_q;

endmodule
